// File: rtl/ocr_pkg.sv
// Shared constants and loader state encoding for the OCR image path.
// Ports: none (package only).
// Imported by the UART image loader and its bench.
package ocr_pkg;

  // Default image geometry (row-major, one byte per pixel).
  localparam int IMG_W = 28;
  localparam int IMG_H = 28;

  // Two-byte frame header.
  localparam logic [7:0] SYNC0 = 8'hAA;
  localparam logic [7:0] SYNC1 = 8'h55;

  // Loader FSM states; encoding is fixed so it can be probed in the lab.
  typedef enum logic [2:0] {
    HUNT0  = 3'd0,
    HUNT1  = 3'd1,
    PIXELS = 3'd2,
    CHECK  = 3'd3,
    HOLD   = 3'd4
  } loader_state_t;

endpackage

// File: rtl/byte_timeout.sv
// Inter-byte watchdog: counts clocks while a frame is in progress.
// Ports: i_Clock/i_Rst_L (async active-low), i_Clear (restart count),
//        i_Run (count enable), o_Expire (combinational, last cycle before limit).
module byte_timeout #(
  parameter int TIMEOUT_CLKS = 208360,
  localparam int TW          = $clog2(TIMEOUT_CLKS + 1)
)(
  input  logic i_Clock,
  input  logic i_Rst_L,
  input  logic i_Clear,
  input  logic i_Run,
  output logic o_Expire
);

  logic [TW-1:0] r_Count;
  logic          w_At_Limit;

  assign w_At_Limit = (r_Count == TW'(TIMEOUT_CLKS - 1));

  // A clear in the same cycle as the limit wins: the byte arrived in time.
  assign o_Expire = i_Run && !i_Clear && w_At_Limit;

  // The counter returns to 0 whenever it is idle, cleared, or has just
  // expired, so it always reads 0 outside an active frame.
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_Count <= '0;
    end else if (i_Clear || !i_Run || w_At_Limit) begin
      r_Count <= '0;
    end else begin
      r_Count <= r_Count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_image_loader.sv
// Frames the UART byte stream: hunts a 2-byte sync header, writes IMG_W*IMG_H
// pixels to the frame buffer, verifies an 8-bit wrapping checksum, and holds a
// good frame (o_Frame_Valid) until the classifier acks it.
// Ports: i_Clock, i_Rst_L (async active-low), i_RX_DV/i_RX_Byte (byte strobe),
//        o_Wr_En/o_Wr_Addr/o_Wr_Data (registered buffer write, 1 cycle after DV),
//        o_Frame_Valid (level), i_Frame_Ack, o_Frame_Done/o_Frame_Err (pulses), o_Busy.
module uart_image_loader #(
  parameter int         IMG_W        = ocr_pkg::IMG_W,
  parameter int         IMG_H        = ocr_pkg::IMG_H,
  parameter logic [7:0] SYNC0        = ocr_pkg::SYNC0,
  parameter logic [7:0] SYNC1        = ocr_pkg::SYNC1,
  parameter int         TIMEOUT_CLKS = 208360,
  localparam int        NPIX         = IMG_W * IMG_H,
  localparam int        AW           = $clog2(NPIX)
)(
  input  logic          i_Clock,
  input  logic          i_Rst_L,
  input  logic          i_RX_DV,
  input  logic [7:0]    i_RX_Byte,
  output logic          o_Wr_En,
  output logic [AW-1:0] o_Wr_Addr,
  output logic [7:0]    o_Wr_Data,
  output logic          o_Frame_Valid,
  input  logic          i_Frame_Ack,
  output logic          o_Frame_Done,
  output logic          o_Frame_Err,
  output logic          o_Busy
);

  import ocr_pkg::*;

  loader_state_t r_State;
  loader_state_t w_State_Next;

  logic [AW-1:0] r_Addr;
  logic [AW-1:0] w_Addr_Next;
  logic [7:0]    r_Sum;
  logic [7:0]    w_Sum_Next;

  logic          w_Wr_En_Next;
  logic [AW-1:0] w_Wr_Addr_Next;
  logic [7:0]    w_Wr_Data_Next;
  logic          w_Valid_Next;
  logic          w_Done_Next;
  logic          w_Err_Next;

  logic          w_Expire;
  logic          w_Last_Pix;

  assign o_Busy     = (r_State == PIXELS) || (r_State == CHECK);
  assign w_Last_Pix = (r_Addr == AW'(NPIX - 1));

  // Watchdog only runs mid-frame; any received byte restarts it, which also
  // covers the clear on entry to PIXELS (entry is always caused by a byte).
  byte_timeout #(
    .TIMEOUT_CLKS (TIMEOUT_CLKS)
  ) u_byte_timeout (
    .i_Clock  (i_Clock),
    .i_Rst_L  (i_Rst_L),
    .i_Clear  (i_RX_DV),
    .i_Run    (o_Busy),
    .o_Expire (w_Expire)
  );

  // State register
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_State <= HUNT0;
    end else begin
      r_State <= w_State_Next;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_State_Next   = r_State;
    w_Addr_Next    = r_Addr;
    w_Sum_Next     = r_Sum;
    w_Wr_En_Next   = 1'b0;
    w_Wr_Addr_Next = o_Wr_Addr;  // address/data hold between writes
    w_Wr_Data_Next = o_Wr_Data;
    w_Valid_Next   = o_Frame_Valid;
    w_Done_Next    = 1'b0;
    w_Err_Next     = 1'b0;

    case (r_State)
      HUNT0: begin
        if (i_RX_DV && (i_RX_Byte == SYNC0)) begin
          w_State_Next = HUNT1;
        end
      end

      HUNT1: begin
        if (i_RX_DV) begin
          if (i_RX_Byte == SYNC1) begin
            w_State_Next = PIXELS;
            w_Addr_Next  = '0;
            w_Sum_Next   = '0;
          end else if (i_RX_Byte != SYNC0) begin
            // A repeated SYNC0 may be the real header start; anything else resets the hunt.
            w_State_Next = HUNT0;
          end
        end
      end

      PIXELS: begin
        // Header values here are pixel data; no re-hunt inside a frame.
        if (i_RX_DV) begin
          w_Wr_En_Next   = 1'b1;
          w_Wr_Addr_Next = r_Addr;
          w_Wr_Data_Next = i_RX_Byte;
          w_Sum_Next     = r_Sum + i_RX_Byte;
          if (w_Last_Pix) begin
            w_State_Next = CHECK;
          end else begin
            w_Addr_Next = r_Addr + 1'b1;
          end
        end else if (w_Expire) begin
          w_Err_Next   = 1'b1;
          w_State_Next = HUNT0;
        end
      end

      CHECK: begin
        if (i_RX_DV) begin
          if (i_RX_Byte == r_Sum) begin
            w_Done_Next  = 1'b1;
            w_Valid_Next = 1'b1;
            w_State_Next = HOLD;
          end else begin
            w_Err_Next   = 1'b1;
            w_State_Next = HUNT0;
          end
        end else if (w_Expire) begin
          w_Err_Next   = 1'b1;
          w_State_Next = HUNT0;
        end
      end

      HOLD: begin
        // Incoming bytes are dropped so the held frame cannot be overwritten.
        if (i_Frame_Ack) begin
          w_Valid_Next = 1'b0;
          w_State_Next = HUNT0;
        end
      end

      default: begin
        w_State_Next = HUNT0;
      end
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_Addr        <= '0;
      r_Sum         <= '0;
      o_Wr_En       <= 1'b0;
      o_Wr_Addr     <= '0;
      o_Wr_Data     <= '0;
      o_Frame_Valid <= 1'b0;
      o_Frame_Done  <= 1'b0;
      o_Frame_Err   <= 1'b0;
    end else begin
      r_Addr        <= w_Addr_Next;
      r_Sum         <= w_Sum_Next;
      o_Wr_En       <= w_Wr_En_Next;
      o_Wr_Addr     <= w_Wr_Addr_Next;
      o_Wr_Data     <= w_Wr_Data_Next;
      o_Frame_Valid <= w_Valid_Next;
      o_Frame_Done  <= w_Done_Next;
      o_Frame_Err   <= w_Err_Next;
    end
  end

endmodule

// File: tb/tb_uart_image_loader.sv
module tb_uart_image_loader;
  import ocr_pkg::*;

  localparam int TO   = 64;
  localparam int NPIX = IMG_W * IMG_H;
  localparam int AW   = $clog2(NPIX);

  localparam int PH_SEEK_A = 0;  // waiting for first header byte
  localparam int PH_SEEK_B = 1;  // have first header byte
  localparam int PH_PIX    = 2;  // collecting pixels
  localparam int PH_SUM    = 3;  // waiting for checksum byte
  localparam int PH_HELD   = 4;  // good frame held

  logic          clk = 1'b0;
  logic          rst_l;
  logic          dv;
  logic [7:0]    rx;
  logic          ack;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          valid, done, err, busy;

  always #5 clk = ~clk;

  uart_image_loader #(.TIMEOUT_CLKS(TO)) dut (
    .i_Clock(clk), .i_Rst_L(rst_l), .i_RX_DV(dv), .i_RX_Byte(rx),
    .o_Wr_En(wr_en), .o_Wr_Addr(wr_addr), .o_Wr_Data(wr_data),
    .o_Frame_Valid(valid), .i_Frame_Ack(ack), .o_Frame_Done(done),
    .o_Frame_Err(err), .o_Busy(busy)
  );

  int checks = 0;
  int failures = 0;

  // Reference model state (stream-level view of a frame)
  int       m_phase, m_npix, m_sum, m_quiet;
  bit       e_wr, e_done, e_err, e_valid, e_busy;
  int       e_addr;
  logic [7:0] e_data;

  // Bench-side frame image and captured buffer
  logic [7:0] pix [NPIX];
  logic [7:0] fb  [NPIX];
  int n_done, n_err, n_wr;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_phase = PH_SEEK_A; m_npix = 0; m_sum = 0; m_quiet = 0;
    e_wr = 0; e_done = 0; e_err = 0; e_valid = 0; e_busy = 0;
    e_addr = 0; e_data = 8'h00;
  endfunction

  function automatic void model_step(input bit d, input logic [7:0] b, input bit a);
    e_wr = 0; e_done = 0; e_err = 0;
    if (m_phase == PH_HELD) begin
      if (a) begin m_phase = PH_SEEK_A; e_valid = 0; end
    end else if (d) begin
      m_quiet = 0;
      if (m_phase == PH_SEEK_A) begin
        if (b == SYNC0) m_phase = PH_SEEK_B;
      end else if (m_phase == PH_SEEK_B) begin
        if (b == SYNC1) begin m_phase = PH_PIX; m_npix = 0; m_sum = 0; end
        else if (b != SYNC0) m_phase = PH_SEEK_A;
      end else if (m_phase == PH_PIX) begin
        e_wr = 1; e_addr = m_npix; e_data = b;
        m_sum += int'(b);
        m_npix++;
        if (m_npix == NPIX) m_phase = PH_SUM;
      end else begin
        if (int'(b) == m_sum % 256) begin m_phase = PH_HELD; e_done = 1; e_valid = 1; end
        else begin m_phase = PH_SEEK_A; e_err = 1; end
      end
    end else if (m_phase == PH_PIX || m_phase == PH_SUM) begin
      m_quiet++;
      if (m_quiet == TO) begin e_err = 1; m_phase = PH_SEEK_A; end
    end
    if (m_phase != PH_PIX && m_phase != PH_SUM) m_quiet = 0;
    e_busy = (m_phase == PH_PIX) || (m_phase == PH_SUM);
  endfunction

  // One clock: drive, clock, update model, compare every output.
  task automatic cycle(input bit d, input logic [7:0] b, input bit a);
    logic [22:0] got, exp;
    dv = d; rx = b; ack = a;
    @(posedge clk);
    model_step(d, b, a);
    #1;
    dv = 0; ack = 0;
    got = {wr_en, wr_addr, wr_data, done, err, valid, busy};
    exp = {e_wr, AW'(e_addr), e_data, e_done, e_err, e_valid, e_busy};
    chk("outputs", 32'(got), 32'(exp));
    if (wr_en) begin
      n_wr++;
      if (int'(wr_addr) < NPIX) fb[wr_addr] = wr_data;
    end
    if (done) n_done++;
    if (err)  n_err++;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int gap;
    cycle(1, b, 0);
    gap = $urandom_range(0, 3);
    for (int g = 0; g < gap; g++)
      cycle(0, 8'h00, (m_phase != PH_HELD) && ($urandom_range(0, 7) == 0));
  endtask

  function automatic logic [7:0] frame_sum();
    int s = 0;
    for (int i = 0; i < NPIX; i++) s += int'(pix[i]);
    return 8'(s % 256);
  endfunction

  task automatic fill_ramp();
    for (int i = 0; i < NPIX; i++) pix[i] = 8'(i % 256);
  endtask

  task automatic fill_rand();
    for (int i = 0; i < NPIX; i++) pix[i] = 8'($urandom_range(0, 255));
  endtask

  task automatic send_pixels_and_sum(input logic [7:0] ck);
    for (int i = 0; i < NPIX; i++) send_byte(pix[i]);
    send_byte(ck);
  endtask

  task automatic clear_counts();
    n_done = 0; n_err = 0; n_wr = 0;
    for (int i = 0; i < NPIX; i++) fb[i] = ~pix[i];
  endtask

  task automatic check_buffer(input string name);
    int bad = 0;
    for (int i = 0; i < NPIX; i++) if (fb[i] !== pix[i]) bad++;
    chk(name, 32'(bad), 32'd0);
  endtask

  typedef struct {
    int              npre;
    logic [3:0][7:0] pre;      // pre[0] sent first
    bit              rnd_pix;
    bit              bad_ck;
    int              exp_done;
    int              exp_err;
  } vec_t;

  vec_t vecs [8];

  initial begin
    logic [7:0] hold_bytes [10];
    int waited;
    bit seen;

    vecs[0] = '{2, {8'h00, 8'h00, 8'h55, 8'hAA}, 1'b0, 1'b0, 1, 0};  // good ramp, cksum F8
    vecs[1] = '{2, {8'h00, 8'h00, 8'h55, 8'hAA}, 1'b0, 1'b1, 0, 1};  // ramp with F7
    vecs[2] = '{2, {8'h00, 8'h00, 8'h55, 8'hAA}, 1'b0, 1'b0, 1, 0};  // recovery frame
    vecs[3] = '{4, {8'h55, 8'hAA, 8'hAA, 8'h12}, 1'b0, 1'b0, 1, 0};  // 12 AA AA 55
    vecs[4] = '{3, {8'h00, 8'h55, 8'h12, 8'hAA}, 1'b0, 1'b0, 0, 0};  // AA 12 55: no lock
    vecs[5] = '{2, {8'h00, 8'h00, 8'h55, 8'hAA}, 1'b1, 1'b0, 1, 0};
    vecs[6] = '{2, {8'h00, 8'h00, 8'h55, 8'hAA}, 1'b1, 1'b1, 0, 1};
    vecs[7] = '{4, {8'h55, 8'hAA, 8'hAA, 8'hAA}, 1'b1, 1'b0, 1, 0};

    hold_bytes = '{8'h11, 8'hAA, 8'h55, 8'h22, 8'hAA, 8'h55, 8'h00, 8'hFF, 8'hAA, 8'h55};

    // Reset state
    rst_l = 0; dv = 0; rx = 0; ack = 0;
    model_reset();
    #3;
    chk("reset_outputs", 32'({wr_en, wr_addr, wr_data, done, err, valid, busy}), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_l = 1;
    for (int i = 0; i < 3; i++) cycle(0, 8'h00, 1);

    // Table-driven frames
    for (int v = 0; v < 8; v++) begin
      if (vecs[v].rnd_pix) fill_rand(); else fill_ramp();
      clear_counts();
      for (int k = 0; k < vecs[v].npre; k++) send_byte(vecs[v].pre[k]);
      send_pixels_and_sum(vecs[v].bad_ck ? frame_sum() - 8'd1 : frame_sum());
      for (int k = 0; k < 3; k++) cycle(0, 8'h00, 0);
      chk($sformatf("v%0d_done", v), 32'(n_done), 32'(vecs[v].exp_done));
      chk($sformatf("v%0d_err", v), 32'(n_err), 32'(vecs[v].exp_err));
      chk($sformatf("v%0d_valid", v), 32'(valid), 32'(vecs[v].exp_done));
      if (vecs[v].exp_done != 0) begin
        check_buffer($sformatf("v%0d_buffer", v));
        cycle(0, 8'h00, 1);
        chk($sformatf("v%0d_valid_after_ack", v), 32'(valid), 32'd0);
      end
    end

    // Timeout: idle after pixel 100 -> Err exactly TO cycles later
    fill_rand(); clear_counts();
    send_byte(SYNC0); send_byte(SYNC1);
    for (int i = 0; i < 99; i++) send_byte(pix[i]);
    cycle(1, pix[99], 0);
    waited = 0; seen = 0;
    for (int i = 1; i <= TO + 8 && !seen; i++) begin
      cycle(0, 8'h00, 0);
      if (err) begin seen = 1; waited = i; end
    end
    chk("timeout_seen", 32'(seen), 32'd1);
    chk("timeout_delay", 32'(waited), 32'(TO));
    chk("timeout_busy", 32'(busy), 32'd0);

    // Timeout: byte on the expiry cycle wins
    clear_counts();
    send_byte(SYNC0); send_byte(SYNC1);
    for (int i = 0; i < 99; i++) send_byte(pix[i]);
    cycle(1, pix[99], 0);
    for (int i = 0; i < TO - 1; i++) cycle(0, 8'h00, 0);
    cycle(1, pix[100], 0);
    chk("expiry_dv_err", 32'(n_err), 32'd0);
    chk("expiry_dv_write", 32'(wr_en), 32'd1);
    for (int i = 0; i < TO + 2; i++) cycle(0, 8'h00, 0);
    chk("expiry_dv_later_err", 32'(n_err), 32'd1);

    // Hold: bytes during HOLD are dropped, ack with DV drops the byte
    fill_ramp(); clear_counts();
    send_byte(SYNC0); send_byte(SYNC1);
    send_pixels_and_sum(frame_sum());
    n_wr = 0;
    for (int i = 0; i < 10; i++) begin cycle(1, hold_bytes[i], 0); cycle(0, 8'h00, 0); end
    chk("hold_writes", 32'(n_wr), 32'd0);
    chk("hold_valid", 32'(valid), 32'd1);
    chk("hold_done", 32'(n_done), 32'd1);
    cycle(1, SYNC0, 1);
    chk("ack_valid", 32'(valid), 32'd0);
    clear_counts();
    send_byte(SYNC1);
    send_pixels_and_sum(frame_sum());
    chk("ack_dv_dropped", 32'(n_done), 32'd0);
    fill_rand(); clear_counts();
    send_byte(SYNC0); send_byte(SYNC1);
    send_pixels_and_sum(frame_sum());
    cycle(0, 8'h00, 0);
    chk("after_hold_done", 32'(n_done), 32'd1);
    check_buffer("after_hold_buffer");
    cycle(0, 8'h00, 1);

    // Reset mid-frame at pixel 400
    fill_rand(); clear_counts();
    send_byte(SYNC0); send_byte(SYNC1);
    for (int i = 0; i < 399; i++) send_byte(pix[i]);
    cycle(1, pix[399], 0);
    rst_l = 0;
    #1;
    chk("midreset_outputs", 32'({wr_en, wr_addr, wr_data, done, err, valid, busy}), 32'd0);
    model_reset();
    @(posedge clk);
    #1 rst_l = 1;
    chk("midreset_err", 32'(n_err), 32'd0);
    fill_rand(); clear_counts();
    send_byte(SYNC0); send_byte(SYNC1);
    send_pixels_and_sum(frame_sum());
    cycle(0, 8'h00, 0);
    chk("post_reset_done", 32'(n_done), 32'd1);
    check_buffer("post_reset_buffer");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
